// File: rtl/coder_pkg.sv
// Shared widths, code type and reset code for the 8-to-3 encoder.
package coder_pkg;
    localparam int N_IN   = 8;
    localparam int CODE_W = 3;

    typedef logic [CODE_W-1:0] code_t;

    localparam code_t RST_CODE = 3'b000;
endpackage

// File: rtl/coder_8to3_if.sv
// Request lines and registered code/flag outputs of the 8-to-3 encoder.
interface coder_8to3_if;
    logic x1, x2, x3, x4, x5, x6, x7, x8;
    logic y1, y2, y3;
    logic valid;
    logic err;

    modport master (
        output x1, x2, x3, x4, x5, x6, x7, x8,
        input  y1, y2, y3, valid, err
    );

    modport slave (
        input  x1, x2, x3, x4, x5, x6, x7, x8,
        output y1, y2, y3, valid, err
    );
endinterface

// File: rtl/coder_prio8.sv
// Combinational 8-input priority encoder: highest set bit wins; any-high flag.
// Latency: 0 (pure logic). Backpressure: none. Multi-hot output only with CODER_ONEHOT_CHECK_EN.
module coder_prio8
    import coder_pkg::*;
(
    input  logic [N_IN-1:0] req,
    output code_t           code,
`ifdef CODER_ONEHOT_CHECK_EN
    output logic            multi,
`endif
    output logic            any
);

    always_comb begin
        code = RST_CODE;
        // Ascending scan so the highest-numbered asserted line overwrites lower ones.
        for (int i = 0; i < N_IN; i++) begin
            if (req[i]) begin
                code = code_t'(i);
            end
        end
    end

    assign any = |req;

`ifdef CODER_ONEHOT_CHECK_EN
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(req & (req - 1'b1));
`endif

endmodule

// File: rtl/coder_8to3.sv
// Registered 8-to-3 priority encoder with valid and optional multi-hot err (CODER_ONEHOT_CHECK_EN).
// Latency: 1 clk, one new code per cycle. Backpressure: none, inputs level-sampled every edge.
// Without CODER_ONEHOT_CHECK_EN the err output is tied low.
module coder_8to3 (
    input logic         clk,
    input logic         rst_n,
    coder_8to3_if.slave bus
);
    import coder_pkg::*;

    logic [N_IN-1:0] req;
    code_t           code_d;
    code_t           code_q;
    logic            any_d;
    logic            valid_q;

    assign req = {bus.x8, bus.x7, bus.x6, bus.x5, bus.x4, bus.x3, bus.x2, bus.x1};

`ifdef CODER_ONEHOT_CHECK_EN
    logic multi_d;
    logic err_q;

    coder_prio8 u_prio (
        .req   (req),
        .code  (code_d),
        .multi (multi_d),
        .any   (any_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= multi_d;
        end
    end

    assign bus.err = err_q;
`else
    coder_prio8 u_prio (
        .req  (req),
        .code (code_d),
        .any  (any_d)
    );

    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q  <= RST_CODE;
            valid_q <= 1'b0;
        end else begin
            code_q  <= code_d;
            valid_q <= any_d;
        end
    end

    assign bus.y1    = code_q[0];
    assign bus.y2    = code_q[1];
    assign bus.y3    = code_q[2];
    assign bus.valid = valid_q;

endmodule

// File: tb/tb_coder_8to3.sv
// Directed-vector bench for coder_8to3; observed value packed as {y3,y2,y1,valid,err}.
module tb_coder_8to3;

`ifdef CODER_ONEHOT_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk    = 1'b0;
    logic clk_en = 1'b0;
    logic rst_n  = 1'b0;
    int   total  = 0;
    int   bad    = 0;

    coder_8to3_if bus ();

    coder_8to3 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = clk_en ? ~clk : clk;

    function automatic logic [4:0] observed();
        return {bus.y3, bus.y2, bus.y1, bus.valid, bus.err};
    endfunction

    task automatic check_out(input string tag, input logic [4:0] got, input logic [4:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got code=%b valid=%b err=%b, want code=%b valid=%b err=%b",
                     tag, got[4:2], got[1], got[0], exp[4:2], exp[1], exp[0]);
        end
    endtask

    task automatic drive_x(input logic [7:0] v);
        {bus.x8, bus.x7, bus.x6, bus.x5, bus.x4, bus.x3, bus.x2, bus.x1} = v;
    endtask

    // Inputs are driven 1 time unit after a rising edge; sample likewise.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hand-computed one-hot sweep expectations: {code, valid, err}.
    logic [4:0] sweep_exp [8] = '{5'b000_1_0, 5'b001_1_0, 5'b010_1_0, 5'b011_1_0,
                                  5'b100_1_0, 5'b101_1_0, 5'b110_1_0, 5'b111_1_0};

    initial begin
        // Reset with no clock and x4 high.
        drive_x(8'b0000_1000);
        #2;
        check_out("reset_no_clk", observed(), 5'b000_0_0);
        #3;
        rst_n = 1'b1;
        #2;
        check_out("after_release_no_edge", observed(), 5'b000_0_0);
        clk_en = 1'b1;
        step();

        for (int k = 0; k < 8; k++) begin
            logic [7:0] v;
            v = 8'b0;
            v[k] = 1'b1;
            drive_x(v);
            step();
            check_out($sformatf("onehot_x%0d", k + 1), observed(), sweep_exp[k]);
        end

        drive_x(8'b0000_0000);
        step();
        check_out("idle", observed(), 5'b000_0_0);

        drive_x(8'b0001_0010);
        step();
        check_out("prio_x2_x5", observed(), {3'b100, 1'b1, ERR_EN});

        drive_x(8'b1111_1111);
        step();
        check_out("prio_all", observed(), {3'b111, 1'b1, ERR_EN});

        drive_x(8'b1000_0001);
        step();
        check_out("prio_x1_x8", observed(), {3'b111, 1'b1, ERR_EN});

        // Latency: outputs must not follow an input change between edges.
        drive_x(8'b0000_0100);
        step();
        check_out("lat_x3", observed(), 5'b010_1_0);
        drive_x(8'b0100_0000);
        #2;
        check_out("lat_hold", observed(), 5'b010_1_0);
        step();
        check_out("lat_x7", observed(), 5'b110_1_0);

        // Mid-stream asynchronous reset with x6 high.
        drive_x(8'b0010_0000);
        step();
        check_out("pre_reset_x6", observed(), 5'b101_1_0);
        rst_n = 1'b0;
        #1;
        check_out("midreset_clear", observed(), 5'b000_0_0);
        rst_n = 1'b1;
        #1;
        check_out("midreset_release", observed(), 5'b000_0_0);
        step();
        check_out("post_reset_x6", observed(), 5'b101_1_0);

        drive_x(8'b0000_0000);
        step();
        check_out("final_idle", observed(), 5'b000_0_0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/coder_8to3.md
# coder_8to3

Registered 8-to-3 one-hot/priority encoder: converts eight single-bit request lines x1..x8 into a 3-bit binary index y3..y1. Sits between a one-hot source (decoder output, arbiter grant, key matrix row) and logic that needs a compact index. Adds a valid flag and an optional multi-hot error flag.

## Interface
- No parameters; widths fixed (N_IN = 8, CODE_W = 3) and taken from the shared package.
- clk  input  1  rising-edge clock; all state in this domain
- rst_n  input  1  asynchronous, active-low reset; release synchronised to clk externally
- x1..x8  input  1 each  request lines; x1 = index 0, x8 = index 7
- y1  output  1  code bit 0 (LSB)
- y2  output  1  code bit 1
- y3  output  1  code bit 2 (MSB)
- valid  output  1  at least one xN was high at the sampling edge
- err  output  1  more than one xN was high at the sampling edge (see Configuration)

## Operation
- Code = index of the highest-numbered asserted input: x8 wins over x7 … over x1.
- One-hot input xK (K = 1..8) -> {y3,y2,y1} = K-1 in binary, valid = 1, err = 0.
- All inputs low -> {y3,y2,y1} = 000, valid = 0, err = 0; downstream must qualify code with valid (x1 alone and no input both give 000).
- Multi-hot input -> code of highest asserted input, valid = 1, err = 1 (when check enabled).
- Inputs are level-sampled each cycle; no handshake, no hold-off, no backpressure.
- X on any input is not masked; verification must drive only 0/1.

## Timing
- All outputs registered; latency exactly 1 clk: inputs present before edge n appear on outputs after edge n, held until edge n+1.
- Throughput: one new code per cycle.
- Reset (rst_n = 0): y1 = y2 = y3 = 0, valid = 0, err = 0 immediately, independent of clk; held while rst_n low.
- Reset asserted mid-stream: outputs clear asynchronously; first post-release edge captures current inputs normally.
- No combinational path from inputs to outputs.

## Configuration
- Macro CODER_ONEHOT_CHECK_EN.
- Defined: err registered = 1 when popcount(x1..x8) ≥ 2, else 0.
- Not defined: popcount logic omitted; err tied to constant 0 (port retained so instantiations do not change). Code/valid behaviour identical in both builds.

## Structure
- Package coder_pkg: N_IN = 8, CODE_W = 3, typedef of 3-bit code, reset code constant 3'b000.
- Sub-module coder_prio8: purely combinational; 8-bit request vector in, 3-bit code + any-high out (plus multi-hot out under the macro). Top level packs x1..x8 into the vector (x1 at bit 0), instantiates coder_prio8, registers outputs with async active-low reset, splits code onto y1..y3.

## Test plan
- Reset: rst_n = 0 with x4 = 1 and no clock -> y3..y1 = 000, valid = 0, err = 0 immediately.
- One-hot sweep: x1..x8 high in turn, one per cycle -> one cycle later {y3,y2,y1} = 000, 001, 010, 011, 100, 101, 110, 111, valid = 1, err = 0 throughout.
- Idle: all inputs 0 -> code 000, valid = 0, err = 0.
- Priority: x2 = x5 = 1 -> code 100, valid = 1, err = 1 (macro defined) / err = 0 (macro undefined); x1..x8 all 1 -> code 111.
- Latency: change x3 -> x7 between edges -> outputs show 010 until the next edge, then 110; no change between edges.
- Mid-stream reset: pulse rst_n low between edges while x6 = 1 -> outputs clear at once; first edge after release -> code 101, valid = 1.
